regfile_sb: RTL

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_rdport.sv | 32 +++
 rtl/regfile_sb.sv | 67 ++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: default geometry and scoreboard error-cause encoding shared by the regfile_sb slice
package regfile_pkg;
  localparam int DEF_XLEN = 32;
  localparam int DEF_NREG = 32;
  localparam int DEF_NRD  = 2;
  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_ISS_BUSY = 2'd1,
    ERR_WB_IDLE  = 2'd2
  } sbCause_e;
endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one combinational read port; REGFILE_BYPASS_EN forwards a same-cycle write-back
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  parameter int AW   = $clog2(DEF_NREG)
) (
  input  logic [AW-1:0]        addr,
  input  logic [NREG*XLEN-1:0] regFlat,
  input  logic [NREG-1:0]      busyVec,
  input  logic                 fwdEn,
  input  logic [AW-1:0]        wbAddr,
  input  logic [XLEN-1:0]      wbData,
  input  logic                 issHit,
  input  logic [AW-1:0]        issAddr,
  output logic [XLEN-1:0]      data,
  output logic                 busy
);
`ifdef REGFILE_BYPASS_EN
  logic fwd;
  assign fwd  = fwdEn && wbAddr == addr;
  assign data = fwd ? wbData : regFlat[int'(addr)*XLEN +: XLEN];
  // a same-cycle issue to the forwarded register makes it pending again
  assign busy = fwd ? issHit && issAddr == addr : busyVec[addr];
`else
  logic unused;
  assign unused = ^{fwdEn, wbAddr, wbData, issHit, issAddr};
  assign data   = regFlat[int'(addr)*XLEN +: XLEN];
  assign busy   = busyVec[addr];
`endif
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with issue/write-back scoreboard and protocol-error pulse
// REGFILE_BYPASS_EN: when defined, reads forward a same-cycle write-back
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  parameter int NRD  = DEF_NRD
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NRD*$clog2(NREG)-1:0]  rd_addr,
  output logic [NRD*XLEN-1:0]          rd_data,
  output logic [NRD-1:0]               rd_busy,
  input  logic                         iss_valid,
  input  logic [$clog2(NREG)-1:0]      iss_addr,
  input  logic                         wb_valid,
  input  logic [$clog2(NREG)-1:0]      wb_addr,
  input  logic [XLEN-1:0]              wb_data,
  input  logic                         flush,
  output logic                         sb_err
);
  localparam int AW = $clog2(NREG);
  logic [NREG*XLEN-1:0] regQ;
  logic [NREG-1:0]      busyQ, busyD;
  logic                 issHit, wbHit;
  sbCause_e             errCause;
  assign issHit = iss_valid && |iss_addr;
  assign wbHit  = wb_valid && |wb_addr;
  always_comb begin
    busyD = flush ? '0 : busyQ;
    if (wbHit) busyD[wb_addr] = 1'b0;
    if (issHit) busyD[iss_addr] = 1'b1;
    busyD[0] = 1'b0;
    errCause = (issHit && busyQ[iss_addr] && !(wbHit && wb_addr == iss_addr)) ? ERR_ISS_BUSY :
               (wbHit && !busyQ[wb_addr]) ? ERR_WB_IDLE : ERR_NONE;
  end
  // slot 0 is never written, so it reads as zero without a special case
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regQ   <= '0;
      busyQ  <= '0;
      sb_err <= 1'b0;
    end else begin
      if (wbHit) regQ[int'(wb_addr)*XLEN +: XLEN] <= wb_data;
      busyQ  <= busyD;
      sb_err <= errCause != ERR_NONE;
    end
  end
  genvar k;
  generate
    for (k = 0; k < NRD; k++) begin : g_rd
      regfile_rdport #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rdport (
        .addr   (rd_addr[k*AW +: AW]),
        .regFlat(regQ),
        .busyVec(busyQ),
        .fwdEn  (wbHit && reset_n),
        .wbAddr (wb_addr),
        .wbData (wb_data),
        .issHit (issHit),
        .issAddr(iss_addr),
        .data   (rd_data[k*XLEN +: XLEN]),
        .busy   (rd_busy[k])
      );
    end
  endgenerate
endmodule
